// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and framing constants.
package uart_ctrl_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned FRAME_BITS     = 10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StGap  = 2'd2
    } arb_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority selector: first valid requester searching upward from last+1.
module uart_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    last_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    logic [ID_W-1:0] k;
    logic            found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        k       = last_i;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            // Explicit wrap keeps non-power-of-two NUM_REQ in range.
            k = (k == ID_W'(NUM_REQ - 1)) ? '0 : k + 1'b1;
            if (!found && valid_i[k]) begin
                found      = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = k;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional watchdog on stalled frames when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_W         = DEFAULT_DATA_W,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 2048
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]          o_req_ready,
    output logic                        o_txstart,
    output logic [DATA_W-1:0]           o_txdata,
    input  logic                        i_txdone,
    output logic                        o_busy,
    output logic [$clog2(NUM_REQ)-1:0]  o_grant_id
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic                        o_timeout
`endif
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(max_u(GAP_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);
`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  ready_q, ready_d;
    logic                txstart_q, txstart_d;
    logic [DATA_W-1:0]   txdata_q, txdata_d;
    logic                busy_q, busy_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`ifdef UART_ARB_TIMEOUT_EN
    logic                timeout_q, timeout_d;
`endif

    logic [NUM_REQ-1:0]  pick_grant;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_any;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .valid_i (i_req_valid),
        .last_i  (grant_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        ready_d   = '0;
        txstart_d = txstart_q;
        txdata_d  = txdata_q;
        busy_d    = busy_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
`ifdef UART_ARB_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    ready_d   = pick_grant;
                    txdata_d  = i_req_data[pick_idx*DATA_W +: DATA_W];
                    grant_d   = pick_idx;
                    txstart_d = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = StSend;
                end
            end
            StSend: begin
                if (i_txdone) begin
                    txstart_d = 1'b0;
                    if (GAP_CYCLES == 0) begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        cnt_d   = GAP_LOAD;
                        state_d = StGap;
                    end
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == TMO_LAST) begin
                    txstart_d = 1'b0;
                    timeout_d = 1'b1;
                    cnt_d     = GAP_LOAD;
                    state_d   = StGap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StGap: begin
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= StIdle;
            ready_q   <= '0;
            txstart_q <= 1'b0;
            txdata_q  <= '0;
            busy_q    <= 1'b0;
            grant_q   <= ID_W'(NUM_REQ - 1);
            cnt_q     <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            txstart_q <= txstart_d;
            txdata_q  <= txdata_d;
            busy_q    <= busy_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    assign o_req_ready = ready_q;
    assign o_txstart   = txstart_q;
    assign o_txdata    = txdata_q;
    assign o_busy      = busy_q;
    assign o_grant_id  = grant_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign o_timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queue-based requesters, random-latency transmitter.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ        = 4;
    localparam int unsigned DATA_W         = 8;
    localparam int unsigned GAP_CYCLES     = 2;
    localparam int unsigned TIMEOUT_CYCLES = 64;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      txstart;
    logic [DATA_W-1:0]         txdata;
    logic                      txdone;
    logic                      busy;
    logic [1:0]                grant_id;
`ifdef UART_ARB_TIMEOUT_EN
    logic                      timeout;
`endif

    int n_chk = 0;
    int n_fail = 0;
    logic [DATA_W-1:0]  q [NUM_REQ][$];
    logic [NUM_REQ-1:0] hs_pend = '0;
    bit tx_auto = 1'b0;
    int tx_cnt = 0;
    int exp_last = NUM_REQ - 1;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .DATA_W         (DATA_W),
        .GAP_CYCLES     (GAP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_txstart   (txstart),
        .o_txdata    (txdata),
        .i_txdone    (txdone),
        .o_busy      (busy),
        .o_grant_id  (grant_id)
`ifdef UART_ARB_TIMEOUT_EN
        ,
        .o_timeout   (timeout)
`endif
    );

    // Requesters keep valid/data through the handshake edge and advance on the next negedge.
    always @(negedge clk) begin
        for (int k = 0; k < NUM_REQ; k++) begin
            if (hs_pend[k] && q[k].size() != 0) void'(q[k].pop_front());
            req_valid[k] = (q[k].size() != 0);
            req_data[k*DATA_W +: DATA_W] = req_valid[k] ? q[k][0] : '0;
        end
        hs_pend = req_ready;
        if (tx_auto) begin
            if (txdone) begin
                txdone = 1'b0;
                tx_cnt = $urandom_range(0, 5);
            end else if (txstart) begin
                if (tx_cnt == 0) txdone = 1'b1;
                else tx_cnt--;
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_ready[k]) begin
                    n_chk++;
                    if (!req_valid[k]) begin
                        n_fail++;
                        $display("FAIL handshake_hold: req %0d ready while valid=0", k);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < NUM_REQ; k++) if (q[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Rule: first pending requester searching upward from last grant + 1.
    function automatic int next_grant(input int last);
        for (int o = 1; o <= NUM_REQ; o++) begin
            if (q[(last + o) % NUM_REQ].size() != 0) return (last + o) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        txdone = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (req_ready !== 4'b0) begin n_fail++;
            $display("FAIL reset_ready: got %b want 0000", req_ready); end
        n_chk++; if (txstart !== 1'b0) begin n_fail++;
            $display("FAIL reset_txstart: got %b want 0", txstart); end
        n_chk++; if (txdata !== 8'h00) begin n_fail++;
            $display("FAIL reset_txdata: got %h want 00", txdata); end
        n_chk++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL reset_busy: got %b want 0", busy); end
        n_chk++; if (grant_id !== 2'd3) begin n_fail++;
            $display("FAIL reset_grant_id: got %0d want 3", grant_id); end
`ifdef UART_ARB_TIMEOUT_EN
        n_chk++; if (timeout !== 1'b0) begin n_fail++;
            $display("FAIL reset_timeout: got %b want 0", timeout); end
`endif
        rst_n = 1'b1;
        exp_last = NUM_REQ - 1;
        tick();
        n_chk++; if (busy !== 1'b0 || txstart !== 1'b0) begin n_fail++;
            $display("FAIL idle_after_reset: busy=%b txstart=%b want 0/0", busy, txstart); end
    endtask

    task automatic test_contention();
        int sel;
        for (int r = 0; r < 4; r++) begin
            int order[$];
            int frames = 0;
            int low_run = 0;
            logic [DATA_W-1:0] cur = '0;
            if (r == 0) begin
                q[0].push_back(8'h10); q[0].push_back(8'h14);
                q[1].push_back(8'h11); q[2].push_back(8'h12); q[3].push_back(8'h13);
            end else begin
                for (int k = 0; k < NUM_REQ; k++)
                    repeat ($urandom_range(0, 3)) q[k].push_back(DATA_W'($urandom));
                if (all_empty()) q[$urandom_range(0, NUM_REQ - 1)].push_back(8'h6E);
            end
            tx_cnt = 1;
            tx_auto = 1'b1;
            for (int c = 0; c < 600; c++) begin
                tick();
                if (req_ready != '0) begin
                    sel = next_grant(exp_last);
                    n_chk++;
                    if (sel < 0) begin
                        n_fail++;
                        $display("FAIL spurious_ready: got %b with nothing pending", req_ready);
                    end else begin
                        if (req_ready !== 4'(1 << sel)) begin n_fail++;
                            $display("FAIL rr_grant: got %b want req %0d", req_ready, sel); end
                        n_chk++; if ({txstart, txdata} !== {1'b1, q[sel][0]}) begin n_fail++;
                            $display("FAIL grant_frame: got start=%b data=%h want 1/%h",
                                     txstart, txdata, q[sel][0]); end
                        n_chk++; if (grant_id !== 2'(sel)) begin n_fail++;
                            $display("FAIL grant_id: got %0d want %0d", grant_id, sel); end
                        if (frames > 0) begin
                            n_chk++; if (low_run != GAP_CYCLES + 1) begin n_fail++;
                                $display("FAIL gap_len: got %0d want %0d", low_run,
                                         GAP_CYCLES + 1); end
                        end
                        cur = q[sel][0];
                        exp_last = sel;
                        order.push_back(sel);
                    end
                    frames++;
                    low_run = 0;
                end else if (txstart) begin
                    n_chk++; if (txdata !== cur) begin n_fail++;
                        $display("FAIL data_stable: got %h want %h", txdata, cur); end
                end else begin
                    low_run++;
                end
                if (!busy && hs_pend == '0 && all_empty()) break;
            end
            n_chk++; if (!all_empty() || busy) begin n_fail++;
                $display("FAIL contention_drain: round %0d busy=%b not drained", r, busy); end
            if (r == 0) begin
                int exp_order[5] = '{0, 1, 2, 3, 0};
                n_chk++; if (order.size() != 5) begin n_fail++;
                    $display("FAIL order_len: got %0d want 5", order.size()); end
                for (int i = 0; i < 5 && i < order.size(); i++) begin
                    n_chk++; if (order[i] != exp_order[i]) begin n_fail++;
                        $display("FAIL order[%0d]: got %0d want %0d", i, order[i],
                                 exp_order[i]); end
                end
            end
            tx_auto = 1'b0;
        end
    endtask

    task automatic test_single();
        int gap_n = 0;
        tx_cnt = 3;
        tx_auto = 1'b1;
        q[2].push_back(8'hA5);
        for (int i = 0; i < 10; i++) begin tick(); if (req_ready != '0) break; end
        n_chk++; if (req_ready !== 4'b0100) begin n_fail++;
            $display("FAIL single_ready: got %b want 0100", req_ready); end
        n_chk++; if ({txstart, txdata, grant_id, busy} !== {1'b1, 8'hA5, 2'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL single_frame: got start=%b data=%h id=%0d busy=%b want 1/a5/2/1",
                     txstart, txdata, grant_id, busy); end
        exp_last = 2;
        tick();
        n_chk++; if (req_ready !== 4'b0 || txstart !== 1'b1) begin n_fail++;
            $display("FAIL single_pulse: ready=%b start=%b want 0000/1", req_ready, txstart); end
        for (int i = 0; i < 20; i++) begin if (txdone) break; tick(); end
        n_chk++; if (txdone !== 1'b1 || txstart !== 1'b0 || busy !== 1'b1) begin n_fail++;
            $display("FAIL single_done: done=%b start=%b busy=%b want 1/0/1",
                     txdone, txstart, busy); end
        for (int i = 0; i < 10; i++) begin if (!busy) break; gap_n++; tick(); end
        n_chk++; if (gap_n != GAP_CYCLES) begin n_fail++;
            $display("FAIL single_gap: got %0d want %0d", gap_n, GAP_CYCLES); end
        tx_auto = 1'b0;
        txdone = 1'b0;
    endtask

    task automatic test_stray_done();
        txdone = 1'b1;
        tick();
        txdone = 1'b0;
        n_chk++; if ({busy, txstart, req_ready} !== 6'b0) begin n_fail++;
            $display("FAIL stray_done: busy=%b start=%b ready=%b want 0/0/0000",
                     busy, txstart, req_ready); end
        n_chk++; if (grant_id !== 2'(exp_last)) begin n_fail++;
            $display("FAIL stray_grant_id: got %0d want %0d", grant_id, exp_last); end
        tick();
        n_chk++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL stray_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp_data[2] = '{8'h58, 8'h3C};
        int frames = 0;
        int low_run = 0;
        q[1].push_back(8'h58);
        q[1].push_back(8'h3C);
        tx_cnt = 2;
        tx_auto = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (req_ready != '0) begin
                n_chk++; if (frames > 1 || req_ready !== 4'b0010 || txdata !== exp_data[frames])
                begin n_fail++;
                    $display("FAIL b2b_frame%0d: ready=%b data=%h want 0010/%h", frames,
                             req_ready, txdata, exp_data[frames % 2]); end
                if (frames == 1) begin
                    n_chk++; if (low_run != GAP_CYCLES + 1) begin n_fail++;
                        $display("FAIL b2b_gap: got %0d want %0d", low_run, GAP_CYCLES + 1); end
                end
                frames++;
                low_run = 0;
            end else if (!txstart) begin
                low_run++;
            end
            if (!busy && hs_pend == '0 && all_empty()) break;
        end
        n_chk++; if (frames != 2) begin n_fail++;
            $display("FAIL b2b_count: got %0d want 2", frames); end
        exp_last = 1;
        tx_auto = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int sel;
        q[1].push_back(8'h77);
        for (int i = 0; i < 10; i++) begin tick(); if (req_ready != '0) break; end
        n_chk++; if (req_ready !== 4'b0010) begin n_fail++;
            $display("FAIL rmf_first: got %b want 0010", req_ready); end
        tick();
        tick();
        q[0].push_back(8'h01);
        q[2].push_back(8'h02);
        n_chk++; if (txstart !== 1'b1) begin n_fail++;
            $display("FAIL rmf_in_send: start=%b want 1", txstart); end
        rst_n = 1'b0;
        #1;
        n_chk++; if ({txstart, busy, req_ready, txdata, grant_id} !== {2'b00, 4'b0, 8'h00, 2'd3})
        begin n_fail++;
            $display("FAIL rmf_async: start=%b busy=%b ready=%b data=%h id=%0d want 0/0/0/00/3",
                     txstart, busy, req_ready, txdata, grant_id); end
        tick();
        tick();
        rst_n = 1'b1;
        exp_last = NUM_REQ - 1;
        for (int i = 0; i < 10; i++) begin tick(); if (req_ready != '0) break; end
        n_chk++; if (req_ready !== 4'b0001 || txdata !== 8'h01) begin n_fail++;
            $display("FAIL rmf_after: ready=%b data=%h want 0001/01", req_ready, txdata); end
        exp_last = 0;
        tx_cnt = 2;
        tx_auto = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (req_ready != '0) begin
                sel = next_grant(exp_last);
                n_chk++; if (sel != 2 || req_ready !== 4'b0100 || txdata !== 8'h02) begin
                    n_fail++;
                    $display("FAIL rmf_second: ready=%b data=%h want 0100/02",
                             req_ready, txdata); end
                exp_last = 2;
            end
            if (!busy && hs_pend == '0 && all_empty()) break;
        end
        n_chk++; if (busy || !all_empty()) begin n_fail++;
            $display("FAIL rmf_drain: busy=%b not drained", busy); end
        tx_auto = 1'b0;
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int sel;
        int hi = 0;
        txdone = 1'b0;
        q[0].push_back(8'hC3);
        sel = next_grant(exp_last);
        for (int i = 0; i < 10; i++) begin tick(); if (req_ready != '0) break; end
        n_chk++; if (req_ready !== 4'(1 << sel) || timeout !== 1'b0) begin n_fail++;
            $display("FAIL tmo_grant: ready=%b tmo=%b want req %0d/0", req_ready, timeout, sel); end
        exp_last = sel;
        q[1].push_back(8'h5A);
        for (int i = 0; i < 200; i++) begin if (!txstart) break; hi++; tick(); end
        n_chk++; if (hi != TIMEOUT_CYCLES) begin n_fail++;
            $display("FAIL tmo_len: got %0d want %0d", hi, TIMEOUT_CYCLES); end
        n_chk++; if ({txstart, timeout, busy} !== 3'b011) begin n_fail++;
            $display("FAIL tmo_flag: start=%b tmo=%b busy=%b want 0/1/1",
                     txstart, timeout, busy); end
        sel = next_grant(exp_last);
        for (int i = 0; i < 10; i++) begin tick(); if (req_ready != '0) break; end
        n_chk++; if (req_ready !== 4'(1 << sel) || txdata !== 8'h5A || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_next: ready=%b data=%h tmo=%b want req %0d/5a/1",
                     req_ready, txdata, timeout, sel); end
        exp_last = sel;
        tx_cnt = 1;
        tx_auto = 1'b1;
        for (int i = 0; i < 40; i++) begin tick(); if (!busy && all_empty()) break; end
        tx_auto = 1'b0;
        n_chk++; if (timeout !== 1'b1 || busy !== 1'b0) begin n_fail++;
            $display("FAIL tmo_sticky: tmo=%b busy=%b want 1/0", timeout, busy); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (timeout !== 1'b0) begin n_fail++;
            $display("FAIL tmo_reset: tmo=%b want 0", timeout); end
        tick();
        rst_n = 1'b1;
        exp_last = NUM_REQ - 1;
    endtask
`endif

    initial begin
        req_valid = '0;
        req_data = '0;
        txdone = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_contention();
        test_single();
        test_stray_done();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
